exu_mc_scheduler: RTL

Sequencer for the EXU's multi-cycle functional units (MDU, FPU, CryptoUnit). It accepts one long-latency op per issue handshake and launches it on the selected unit with a one-cycle start pulse. It waits for that unit's done pulse, then holds the result on a valid/ready writeback port. It also provides flush kill, a watchdog timeout and illegal-unit detection, and replaces ad-hoc OR-ing of unit busy flags with an explicit FSM.

---
 rtl/exu_sched_pkg.sv | 23 ++
 rtl/sched_watchdog.sv | 39 +++
 rtl/exu_mc_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/exu_sched_pkg.sv
// Shared types for the EXU multi-cycle unit scheduler.
// Unit indices, FSM states and the writeback bundle.
package exu_sched_pkg;

    localparam int unsigned UNIT_MDU    = 0;
    localparam int unsigned UNIT_FPU    = 1;
    localparam int unsigned UNIT_CRYPTO = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        timeout;
        logic        illegal;
    } sched_wb_t;

endpackage

// File: rtl/sched_watchdog.sv
// Watchdog counter for the WAIT state of the scheduler.
// Expires when the count reaches WATCHDOG_CYCLES-1.
module sched_watchdog #(
    parameter int unsigned WATCHDOG_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (WATCHDOG_CYCLES > 2) ?
                                    $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WATCHDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/exu_mc_scheduler.sv
// Issue/launch/wait/writeback sequencer for the EXU
// multi-cycle units (MDU, FPU, Crypto).
module exu_mc_scheduler
    import exu_sched_pkg::*;
#(
    parameter int unsigned NUM_UNITS       = 3,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned TAG_W           = 5,
    parameter int unsigned WATCHDOG_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [1:0]                issue_unit,
    input  logic [TAG_W-1:0]          issue_tag,
    output logic [NUM_UNITS-1:0]      unit_start,
    output logic [NUM_UNITS-1:0]      unit_kill,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*XLEN-1:0] unit_result,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [XLEN-1:0]           wb_data,
    output logic [TAG_W-1:0]          wb_tag,
    output logic                      wb_timeout,
    output logic                      wb_illegal,
    output logic                      sched_busy
);

    sched_state_t state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic timeout_q, timeout_d;
    logic illegal_q, illegal_d;

    logic [NUM_UNITS-1:0] sel_oh;
    logic [XLEN-1:0]      sel_result;
    logic                 sel_done;
    logic                 wd_clr;
    logic                 wd_en;
    logic                 wd_expire;
    logic                 accept;

    always_comb begin
        sel_oh     = '0;
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_q == 2'(i)) begin
                sel_oh[i]  = 1'b1;
                sel_result = unit_result[i*XLEN +: XLEN];
            end
        end
    end

    assign sel_done    = |(unit_done & sel_oh);
    assign issue_ready = (state_q == IDLE) & ~flush;
    assign accept      = issue_valid & issue_ready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        tag_d      = tag_q;
        timeout_d  = timeout_q;
        illegal_d  = illegal_q;
        unit_start = '0;
        unit_kill  = '0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d     = issue_unit;
                    tag_d     = issue_tag;
                    data_d    = '0;
                    timeout_d = 1'b0;
                    if (32'(issue_unit) < NUM_UNITS) begin
                        illegal_d = 1'b0;
                        state_d   = LAUNCH;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            LAUNCH: begin
                if (flush) begin
                    unit_kill = sel_oh;
                    state_d   = IDLE;
                end else begin
                    unit_start = sel_oh;
                    wd_clr     = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    unit_kill = sel_oh;
                    state_d   = IDLE;
                end else if (sel_done) begin
                    data_d    = sel_result;
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (wd_expire) begin
                    unit_kill = sel_oh;
                    data_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_en = 1'b1;
                end
            end
            DONE: begin
                if (flush || wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    sched_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_wd (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    assign wb_valid   = (state_q == DONE);
    assign wb_data    = data_q;
    assign wb_tag     = tag_q;
    assign wb_timeout = timeout_q;
    assign wb_illegal = illegal_q;
    assign sched_busy = (state_q != IDLE);

endmodule
